// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
//   Shared definitions for the 4x4 keypad scanner: matrix geometry, FSM state
//   encoding and small helpers for deriving counter widths and key codes.
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KEY_W    = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    // Last value of the per-column step counter.
    function automatic int calc_step_max(input int clk_hz, input int rate_hz);
        return clk_hz / rate_hz - 1;
    endfunction

    // Bits needed to hold 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Snapshot bits are laid out col*4+row; key codes are row*4+col.
    function automatic logic [KEY_W-1:0] snap_idx_to_code(input logic [KEY_W-1:0] idx);
        return {idx[1:0], idx[3:2]};
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [KEY_W-1:0] onehot_index(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) idx = idx | KEY_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
//   Free-running modulo counter 0..MAX_COUNT with a one-cycle rollover pulse.
//   Ports:
//     clk_i       clock, rising edge
//     rst_ni      asynchronous active-low reset
//     clear_i     synchronous clear (dominates count_en_i)
//     count_en_i  advance the counter
//     rollover_o  high in the cycle the counter wraps from MAX_COUNT to 0
// -----------------------------------------------------------------------------
module flex_counter #(
    parameter int MAX_COUNT = 3,
    parameter int WIDTH     = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic rollover_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (count_en_i) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign rollover_o = count_en_i && !clear_i && (r_count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low key matrix one column at a time, debounces whole
//   scans and delivers single-key presses through a valid/ready handshake.
//   Ports:
//     clk_i          clock, rising edge
//     rst_ni         asynchronous active-low reset
//     scan_en_i      scanning enable; low forces idle and clears scan state
//     rows_i[3:0]    row sense lines, active-low, asynchronous
//     cols_o[3:0]    column drives, active-low, at most one low
//     key_code_o     key index row*4+col of the delivered key
//     key_valid_o    key_code_o holds an undelivered key
//     key_ready_i    consumer accepts key_code_o
//     key_pressed_o  debounced state has at least one key down
//     overrun_o      one-cycle pulse when a key event is dropped
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ  = 100_000_000,
    parameter int SCAN_RATE_HZ   = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                scan_en_i,
    input  logic [NUM_ROWS-1:0] rows_i,
    output logic [NUM_COLS-1:0] cols_o,
    output logic [KEY_W-1:0]    key_code_o,
    output logic                key_valid_o,
    input  logic                key_ready_i,
    output logic                key_pressed_o,
    output logic                overrun_o
);

    localparam int STEP_MAX = calc_step_max(CLOCK_FREQ_HZ, SCAN_RATE_HZ);
    localparam int STEP_W   = cnt_width(STEP_MAX);
    localparam int STAB_W   = cnt_width(DEBOUNCE_SCANS);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] r_rows_meta, r_rows_sync;
    state_t              r_state, w_state_next;
    logic [1:0]          r_col;
    logic [NUM_KEYS-1:0] r_snap, r_prev, r_deb;
    logic [STAB_W-1:0]   r_stable, w_stable_next;
    logic [NUM_KEYS-1:0] w_deb_next;
    logic                w_tick, w_step_clr, w_event;
    logic [KEY_W-1:0]    r_code;
    logic                r_valid, r_pressed, r_ovr;
    logic [NUM_COLS-1:0] w_cols;

    // Row synchronizer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rows_meta <= '0;
            r_rows_sync <= '0;
        end else begin
            r_rows_meta <= rows_i;
            r_rows_sync <= r_rows_meta;
        end
    end

    // Held at zero in IDLE so the first column gets a full step after entry.
    assign w_step_clr = !scan_en_i || (r_state == ST_IDLE);

    flex_counter #(
        .MAX_COUNT (STEP_MAX),
        .WIDTH     (STEP_W)
    ) u_step (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (w_step_clr),
        .count_en_i (scan_en_i),
        .rollover_o (w_tick)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // FSM next state and column drive
    always_comb begin
        w_state_next = r_state;
        w_cols       = '1;
        case (r_state)
            ST_IDLE: begin
                if (scan_en_i) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                w_cols = ~(NUM_COLS'(1) << r_col);
                if (!scan_en_i)                  w_state_next = ST_IDLE;
                else if (w_tick && r_col == 2'd3) w_state_next = ST_EVAL;
            end
            ST_EVAL: begin
                // Column has already wrapped to 0; EVAL overlaps its first cycle.
                w_cols = ~(NUM_COLS'(1) << r_col);
                if (!scan_en_i) w_state_next = ST_IDLE;
                else            w_state_next = ST_SCAN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign cols_o = w_cols;

    // Debounce: count consecutive identical full scans
    always_comb begin
        if (r_snap == r_prev)
            w_stable_next = (r_stable == STAB_MAX) ? r_stable : r_stable + 1'b1;
        else
            w_stable_next = STAB_W'(1);
    end

    assign w_deb_next = (r_state == ST_EVAL && w_stable_next == STAB_MAX) ? r_snap : r_deb;

    // Only a transition from nothing pressed to exactly one key is an event.
    assign w_event = scan_en_i && (r_state == ST_EVAL) && (r_deb == '0) && $onehot(w_deb_next);

    // Scan datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col    <= '0;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_deb    <= '0;
        end else if (!scan_en_i) begin
            r_col    <= '0;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_deb    <= '0;
        end else begin
            if (r_state == ST_SCAN && w_tick) begin
                r_snap[{r_col, 2'b00} +: NUM_ROWS] <= ~r_rows_sync;
                r_col <= r_col + 1'b1;
            end
            if (r_state == ST_EVAL) begin
                r_stable <= w_stable_next;
                r_prev   <= r_snap;
                r_deb    <= w_deb_next;
            end
        end
    end

    // Output handshake; survives scan_en_i dropping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_pressed <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ovr     <= 1'b0;
            r_pressed <= |r_deb;
            if (w_event) begin
                if (r_valid && !key_ready_i) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_code  <= snap_idx_to_code(onehot_index(w_deb_next));
                end
            end else if (r_valid && key_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign key_code_o    = r_code;
    assign key_valid_o   = r_valid;
    assign key_pressed_o = r_pressed;
    assign overrun_o     = r_ovr;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 100_000_000: input clock frequency.
REQ-002 SHALL have parameter SCAN_RATE_HZ, default 1000: column step rate; each column is driven for 1/SCAN_RATE_HZ s.
REQ-003 SHALL have parameter DEBOUNCE_SCANS, default 4: number of identical consecutive full scans required to accept a new key state.
REQ-004 SHALL have port clk_i  input  1: single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port scan_en_i  input  1: enables scanning; low means idle.
REQ-007 SHALL have port rows_i  input  4: row sense lines, active-low (pulled up externally), asynchronous to clk_i.
REQ-008 SHALL have port cols_o  output  4: column drives, active-low, at most one bit low.
REQ-009 SHALL have port key_code_o  output  4: pressed key index, row*4 + col.
REQ-010 SHALL have port key_valid_o  output  1: key_code_o holds an undelivered key.
REQ-011 SHALL have port key_ready_i  input  1: consumer accepts key_code_o.
REQ-012 SHALL have port key_pressed_o  output  1: level; the debounced state has one or more keys down.
REQ-013 SHALL have port overrun_o  output  1: one-cycle pulse when a key event is dropped.

Function
REQ-014 SHALL pass rows_i through a 2-flop synchronizer before any use.
REQ-015 SHALL generate a one-cycle tick every STEP_MAX+1 clocks, where STEP_MAX = CLOCK_FREQ_HZ/SCAN_RATE_HZ - 1, while scan_en_i is high.
REQ-016 SHALL use an FSM with states IDLE, SCAN and EVAL; IDLE->SCAN when scan_en_i=1, with column 0 driven and the step counter at 0.
REQ-017 In SCAN, SHALL on each tick store the inverted synchronized rows into snapshot bits [col*4+3:col*4], then drive the next column (0->1->2->3).
REQ-018 On the tick for column 3, SHALL go to EVAL for exactly one cycle, then return to SCAN at column 0.
REQ-019 In EVAL, SHALL increment the stable count (saturating at DEBOUNCE_SCANS) if snapshot equals the previous snapshot, else reset it to 1, then store snapshot as previous.
REQ-020 In EVAL, when the stable count reaches DEBOUNCE_SCANS, SHALL copy the snapshot to the 16-bit debounced state.
REQ-021 SHALL raise a key event only when the debounced state goes from all-zero to exactly one bit set; key_code_o is that bit's index.
REQ-022 Multi-key debounced states SHALL produce no event; there SHALL be no auto-repeat, so a full debounced release is required before the next event.
REQ-023 The key event SHALL appear as key_valid_o=1 on the cycle after EVAL.
REQ-024 key_valid_o and key_code_o SHALL hold stable until key_valid_o && key_ready_i; key_valid_o clears on the next cycle unless a new event loads in the same cycle.
REQ-025 An event with key_valid_o=1 and key_ready_i=0 SHALL be dropped and pulse overrun_o for one cycle; the held key_code_o is kept.
REQ-026 When scan_en_i drops, next cycle: cols_o=4'hF, FSM to IDLE, and step counter, snapshot, previous snapshot, stable count and debounced state cleared; key_valid_o/key_code_o retained.
REQ-027 key_pressed_o SHALL equal OR-reduction of the debounced state, registered.

Reset
REQ-028 On rst_ni=0, SHALL immediately set cols_o=4'hF, key_code_o=0, key_valid_o=0, key_pressed_o=0, overrun_o=0, and FSM=IDLE, with all counters, snapshots and synchronizer flops cleared.
REQ-029 Reset deassertion SHALL be the only way to leave reset; scanning resumes from column 0 on the first clock with scan_en_i=1.

Structure
REQ-030 STEP_MAX, counter widths ($clog2) and FSM state encodings SHALL be localparams in a shared keypad_defs header, not hard-coded.
REQ-031 The step tick SHALL be generated by the existing flex_counter sub-module (MAX_COUNT=STEP_MAX); no other sub-modules.
REQ-032 RTL SHALL be 120-400 lines, using a single clock domain apart from the row synchronizer.

Verification (CLOCK_FREQ_HZ=16, SCAN_RATE_HZ=4 -> tick every 4 clocks; DEBOUNCE_SCANS=2)
REQ-033 Reset, scan_en_i=1, no key -> cols_o cycles 1110,1101,1011,0111 every 4 clocks; key_valid_o stays 0.
REQ-034 Hold row1/col2 low for 3 scans, key_ready_i=1 -> one key_valid_o pulse with key_code_o=6; key_pressed_o=1 until release is debounced.
REQ-035 Bounce: key toggles each scan for 4 scans, then stable -> no event until 2 identical scans, then exactly one event.
REQ-036 Keys 0 and 15 pressed together -> no event, key_pressed_o=1; release one -> still no event.
REQ-037 key_ready_i=0, press 3, release, press 9 -> key_code_o stays 3, overrun_o pulses once; ready=1 -> transfer and key_valid_o=0 next cycle.
REQ-038 rst_ni low mid-scan with key_valid_o=1 -> all outputs at reset values asynchronously; scan_en_i low mid-scan -> cols_o=4'hF next cycle, key_valid_o retained.
